// File: rtl/pipelined_cpu_if.sv
// Bus bundle for pipelined_cpu: instruction-memory write port, retire stream and debug register read.
interface pipelined_cpu_if #(
   parameter int DATA_W     = 8,
   parameter int NREG       = 16,
   parameter int IMEM_DEPTH = 256
);
   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int RI_W = $clog2(NREG);

   logic              i_imem_we;
   logic [PC_W-1:0]   i_imem_waddr;
   logic [15:0]       i_imem_wdata;
   logic [RI_W-1:0]   i_dbg_addr;
   logic [PC_W-1:0]   o_pc;
   logic              o_halted;
   logic              o_retire_valid;
   logic [RI_W-1:0]   o_retire_rd;
   logic [DATA_W-1:0] o_retire_data;
   logic [DATA_W-1:0] o_dbg_data;

   modport master (
      output i_imem_we, i_imem_waddr, i_imem_wdata, i_dbg_addr,
      input  o_pc, o_halted, o_retire_valid, o_retire_rd, o_retire_data, o_dbg_data
   );

   modport slave (
      input  i_imem_we, i_imem_waddr, i_imem_wdata, i_dbg_addr,
      output o_pc, o_halted, o_retire_valid, o_retire_rd, o_retire_data, o_dbg_data
   );
endinterface

// File: rtl/pipelined_cpu.sv
// Four-stage IF/ID/EX/WB core for the 16-bit instruction set, with EX forwarding,
// write-through register reads, a hard-wired R0 and a HALT that drains the pipe.
module pipelined_cpu #(
   parameter int DATA_W     = 8,
   parameter int NREG       = 16,
   parameter int IMEM_DEPTH = 256
) (
   input logic            clk,
   input logic            rst,
   pipelined_cpu_if.slave bus
);
   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int RI_W = $clog2(NREG);

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t r_state;
   state_t w_nextState;

   logic [15:0]       r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0] r_regs [NREG];
   logic [PC_W-1:0]   r_pc;

   logic              r_ifIdValid;
   logic [15:0]       r_ifIdInstr;

   logic              r_idExValid;
   logic [3:0]        r_idExOp;
   logic [RI_W-1:0]   r_idExRd;
   logic [RI_W-1:0]   r_idExRs1;
   logic [RI_W-1:0]   r_idExRs2;
   logic [DATA_W-1:0] r_idExA;
   logic [DATA_W-1:0] r_idExB;
   logic [DATA_W-1:0] r_idExImm;
   logic              r_idExWrite;
   logic              r_idExHalt;

   logic              r_exWbValid;
   logic [RI_W-1:0]   r_exWbRd;
   logic [DATA_W-1:0] r_exWbData;
   logic              r_exWbWrite;
   logic              r_exWbHalt;

   logic [3:0]        w_idOp;
   logic [RI_W-1:0]   w_idRd;
   logic [RI_W-1:0]   w_idRs1;
   logic [RI_W-1:0]   w_idRs2;
   logic [DATA_W-1:0] w_idA;
   logic [DATA_W-1:0] w_idB;
   logic              w_idWrite;
   logic              w_idHalt;
   logic              w_wbWrites;
   logic              w_fetchEn;
   logic              w_halted;
   logic [DATA_W-1:0] w_exA;
   logic [DATA_W-1:0] w_exB;
   logic [DATA_W-1:0] w_exResult;

   assign w_idOp    = r_ifIdInstr[15:12];
   assign w_idRd    = r_ifIdInstr[8 +: RI_W];
   assign w_idRs1   = r_ifIdInstr[4 +: RI_W];
   assign w_idRs2   = r_ifIdInstr[0 +: RI_W];
   assign w_idWrite = (w_idOp >= OP_ADD) && (w_idOp <= OP_LDI);
   assign w_idHalt  = r_ifIdValid && (w_idOp == OP_HALT);

   // R0 never gets written, so the WB bypass and the regfile write share one qualifier.
   assign w_wbWrites = r_exWbValid && r_exWbWrite && (r_exWbRd != '0);

   assign w_idA = (w_wbWrites && (r_exWbRd == w_idRs1)) ? r_exWbData : r_regs[w_idRs1];
   assign w_idB = (w_wbWrites && (r_exWbRd == w_idRs2)) ? r_exWbData : r_regs[w_idRs2];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_RUN:    if (w_idHalt) w_nextState = S_DRAIN;
         S_DRAIN:  if (r_exWbValid && r_exWbHalt) w_nextState = S_HALTED;
         S_HALTED: w_nextState = S_HALTED;
         default:  w_nextState = S_RUN;
      endcase
   end

   // A HALT sitting in ID already blocks this cycle's fetch, before the state moves to DRAIN.
   always_comb begin
      w_fetchEn = 1'b0;
      w_halted  = 1'b0;
      case (r_state)
         S_RUN:    w_fetchEn = !w_idHalt;
         S_HALTED: w_halted  = 1'b1;
         default:  w_fetchEn = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (bus.i_imem_we) begin
         r_imem[bus.i_imem_waddr] <= bus.i_imem_wdata;
      end
   end

   always_comb begin
      w_exA = r_idExA;
      w_exB = r_idExB;
      if (w_wbWrites && (r_exWbRd == r_idExRs1)) w_exA = r_exWbData;
      if (w_wbWrites && (r_exWbRd == r_idExRs2)) w_exB = r_exWbData;
   end

   always_comb begin
      w_exResult = '0;
      case (r_idExOp)
         OP_ADD:  w_exResult = w_exA + w_exB;
         OP_SUB:  w_exResult = w_exA - w_exB;
         OP_AND:  w_exResult = w_exA & w_exB;
         OP_OR:   w_exResult = w_exA | w_exB;
         OP_XOR:  w_exResult = w_exA ^ w_exB;
         OP_LDI:  w_exResult = r_idExImm;
         default: w_exResult = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= '0;
         r_ifIdValid <= 1'b0;
         r_ifIdInstr <= '0;
         r_idExValid <= 1'b0;
         r_idExOp    <= '0;
         r_idExRd    <= '0;
         r_idExRs1   <= '0;
         r_idExRs2   <= '0;
         r_idExA     <= '0;
         r_idExB     <= '0;
         r_idExImm   <= '0;
         r_idExWrite <= 1'b0;
         r_idExHalt  <= 1'b0;
         r_exWbValid <= 1'b0;
         r_exWbRd    <= '0;
         r_exWbData  <= '0;
         r_exWbWrite <= 1'b0;
         r_exWbHalt  <= 1'b0;
      end else begin
         if (w_fetchEn) begin
            r_ifIdInstr <= r_imem[r_pc];
            r_pc        <= r_pc + PC_W'(1);
         end
         r_ifIdValid <= w_fetchEn;

         r_idExValid <= r_ifIdValid;
         r_idExOp    <= w_idOp;
         r_idExRd    <= w_idRd;
         r_idExRs1   <= w_idRs1;
         r_idExRs2   <= w_idRs2;
         r_idExA     <= w_idA;
         r_idExB     <= w_idB;
         r_idExImm   <= DATA_W'(r_ifIdInstr[7:0]);
         r_idExWrite <= w_idWrite;
         r_idExHalt  <= (w_idOp == OP_HALT);

         r_exWbValid <= r_idExValid;
         r_exWbRd    <= r_idExRd;
         r_exWbData  <= w_exResult;
         r_exWbWrite <= r_idExWrite;
         r_exWbHalt  <= r_idExHalt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wbWrites) begin
         r_regs[r_exWbRd] <= r_exWbData;
      end
   end

   assign bus.o_pc           = r_pc;
   assign bus.o_halted       = w_halted;
   assign bus.o_retire_valid = r_exWbValid;
   assign bus.o_retire_rd    = r_exWbRd;
   assign bus.o_retire_data  = r_exWbData;
   assign bus.o_dbg_data     = r_regs[bus.i_dbg_addr];
endmodule

// File: doc/pipelined_cpu.md
# pipelined_cpu

Four-stage (IF/ID/EX/WB) pipelined successor to the single-cycle 16-bit-instruction CPU.
- Generalised: parametrised data width, register count and instruction-memory depth.
- New behaviour: writable instruction memory, operand forwarding, hard-wired zero register, immediate load, drained HALT, and retire/debug observation ports.
- Top-level execution core of the mini RISC design.

## Interface
- DATA_W, 8: datapath and register width (>= 8).
- NREG, 16: register count (power of two, <= 16); register index is instruction field bits [log2(NREG)-1:0].
- IMEM_DEPTH, 256: instruction words (power of two, <= 256); PC width PC_W = log2(IMEM_DEPTH).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_we  in  1  instruction-memory write enable.
- imem_waddr  in  PC_W  write address.
- imem_wdata  in  16  instruction word.
- pc  out  PC_W  current fetch address.
- halted  out  1  HALT has retired; pipeline empty.
- retire_valid  out  1  an instruction is in WB this cycle.
- retire_rd  out  log2(NREG)  WB destination index.
- retire_data  out  DATA_W  WB result.
- dbg_addr  in  log2(NREG)  debug register select.
- dbg_data  out  DATA_W  combinational read of register dbg_addr, post-bypass view not included.

## Operation
- Format: opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0].
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 LDI: rd = zero-extended {rs1,rs2} imm8.
  - F HALT.
  - 7-E: treated as NOP (no write).
- Arithmetic is modulo 2^DATA_W; no flags.
- R0 reads as 0 always; writes to R0 are discarded (retire_valid still pulses, retire_data shows the computed value).
- Stages:
  - IF: latch imem[pc] into IF/ID with valid=1; pc <= pc+1, wrapping IMEM_DEPTH-1 -> 0.
  - ID: decode; read rs1/rs2 from the regfile with write-through, so a same-cycle WB write to a matching index returns the new value.
  - EX: ALU. Each operand is replaced by the EX/WB result when EX/WB is valid, writes, rd==rs, and rd!=0. Forwarding priority: EX/WB over ID-read value.
  - WB: write regfile at end of cycle; drive retire_*.
- No stalls are needed: distance-1 dependences use EX forwarding, distance-2 dependences use write-through.
- HALT:
  - When HALT is in ID, pc freezes and the word being fetched that cycle is squashed (IF/ID valid <= 0).
  - Fetch remains stopped; older instructions drain.
  - halted <= 1 on the edge HALT leaves WB; it holds until rst.
  - HALT itself asserts retire_valid with no regfile write.
- Imem write port is usable any time. A write and a fetch to the same address in the same cycle returns the old word.
- Imem is not reset.

## Timing
- Reset (synchronous): pc=0, all stage valids=0, halted=0, retire_valid=0, retire_rd=0, retire_data=0, all registers 0.
- rst mid-operation: every in-flight instruction is discarded, with no write on that edge.
- The instruction at pc=0 is fetched in the first cycle rst is low. It is in WB (retire_valid=1) in the 4th cycle after release, and the regfile is updated at the end of that cycle.
- Throughput is 1 instruction/cycle. Fixed latency of 3 edges from fetch edge to WB cycle.
- pc output timing:
  - pc equals the address fetched this cycle.
  - With HALT at address h: pc freezes at h+1 (mod IMEM_DEPTH).
  - halted rises 3 cycles after HALT was fetched plus one edge.
- dbg_data is combinational from the register array.

## Test plan
- Preload R2=5, R3=7 via LDI at addresses 0 and 1, then ADD R1=R2+R3, then HALT -> retire order R2=5, R3=7, R1=12, then HALT; halted=1; dbg R1=0x0C.
- Back-to-back chain LDI R1,0xFF; ADD R2=R1+R1; SUB R3=R2-R1; XOR R4=R3,R1 -> R2=0xFE (forward), R3=0xFF (forward plus write-through), R4=0x00; no bubbles, 4 retires in 4 consecutive cycles.
- R0 behaviour: LDI R0,0x55; ADD R1=R0+R0 -> R1=0, dbg R0=0, retire_data of first instruction = 0x55.
- HALT drain: HALT at address 3 followed by LDI R5,0x11 -> R5 stays 0, pc holds 4, halted holds for 10+ cycles.
- Reset mid-stream: assert rst while 3 instructions are in flight -> next cycle all outputs at reset values and registers 0. Reload imem, release rst, rerun: correct results.
- PC wrap (IMEM_DEPTH=16): NOP at 0..14, LDI R1,0x2A at 15, HALT at 0 on wrap -> pc sequence ...15, 0, then freeze at 1; R1=0x2A.
